// File: rtl/arm_regfile.sv
// arm_regfile -- architectural integer register file for the 64-bit ARM core.
//
// Holds X0-X30 (DATA_W bits each). X31 is the zero register (XZR): it has no
// storage, ignores writes and always reads as 0.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset; clears X0-X30 and drops any write
//             presented at the same edge
//   wr_en     write-back RegWrite, qualifies the write decoder
//   wr_addr   destination register number
//   wr_data   write-back result
//   rd_addr1  read port 1 register number (Rn)
//   rd_addr2  read port 2 register number (Rm/Rt)
//   rd_data1  read port 1 data (combinational)
//   rd_data2  read port 2 data (combinational)
//
// Build option:
//   ARM_REGFILE_BYPASS_EN  when defined, a read of the register being written
//                          in the same cycle returns wr_data (write-first).
//                          When undefined, reads return the stored value and
//                          the new data appears the cycle after the write.

module arm_regfile #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    localparam int                NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] XZR  = ADDR_W'(NREG - 1);

    // Storage for X0..X30 only.
    logic [DATA_W-1:0] regs [NREG-1];

    // One-hot write enable. The XZR line is hardwired to 0, so only the
    // lines that reach real storage are built. Gating with wr_en first keeps
    // an unknown wr_addr from reaching any enable while wr_en is low.
    logic [NREG-2:0] wr_dec;

    always_comb begin
        wr_dec = '0;
        for (int i = 0; i < NREG - 1; i++) begin
            wr_dec[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG - 1; i++) begin
            if (!reset_n) begin
                regs[i] <= '0;
            end else if (wr_dec[i]) begin
                regs[i] <= wr_data;
            end
        end
    end

    // 32:1 read muxes; address 31 matches no storage entry and falls through
    // to the zero default.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        for (int i = 0; i < NREG - 1; i++) begin
            if (rd_addr1 == ADDR_W'(i)) rd_data1 = regs[i];
            if (rd_addr2 == ADDR_W'(i)) rd_data2 = regs[i];
        end
`ifdef ARM_REGFILE_BYPASS_EN
        // Write-first forwarding closes the WB->ID hazard. A write that the
        // reset edge will discard is not forwarded, and XZR never is.
        if (reset_n && wr_en && (wr_addr != XZR) && (wr_addr == rd_addr1))
            rd_data1 = wr_data;
        if (reset_n && wr_en && (wr_addr != XZR) && (wr_addr == rd_addr2))
            rd_data2 = wr_data;
`endif
    end

endmodule

// File: tb/tb_arm_regfile.sv
// Directed bench for arm_regfile. A reference model of X0-X31 predicts every
// read; expectations are queued when a read is set up and popped when the
// combinational outputs are sampled. Compile with +define+ARM_REGFILE_BYPASS_EN
// to check the forwarding build.

module tb_arm_regfile;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    arm_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mdl [32];
    logic [DATA_W-1:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    // Value a read port should show right now, given model state and the
    // write currently presented.
    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = (a == 5'd31) ? '0 : mdl[a];
`ifdef ARM_REGFILE_BYPASS_EN
        if (reset_n === 1'b1 && wr_en === 1'b1 && wr_addr !== 5'd31 && wr_addr === a)
            v = wr_data;
`endif
        return v;
    endfunction

    task automatic set_wr(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en = en; wr_addr = a; wr_data = d;
    endtask

    // One rising edge; the model follows the same edge, then inputs may change
    // safely at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n === 1'b0) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
        end else if (wr_en === 1'b1 && wr_addr !== 5'd31) begin
            mdl[wr_addr] = wr_data;
        end
        @(negedge clk);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2, input string tag);
        logic [DATA_W-1:0] e1, e2;
        rd_addr1 = a1;
        rd_addr2 = a2;
        exp_q.push_back(exp_rd(a1));
        exp_q.push_back(exp_rd(a2));
        #1;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_tests++;
        assert (rd_data1 === e1) else begin
            n_fail++;
            $error("FAIL %s port1 addr=%0d got=%h exp=%h", tag, a1, rd_data1, e1);
        end
        n_tests++;
        assert (rd_data2 === e2) else begin
            n_fail++;
            $error("FAIL %s port2 addr=%0d got=%h exp=%h", tag, a2, rd_data2, e2);
        end
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 32; a++) rd(5'(a), 5'(31 - a), tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 'x;   // unknown address with wr_en low must be harmless
        wr_data  = 64'h1234;
        rd_addr1 = '0;
        rd_addr2 = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 'x;
        @(negedge clk);

        // Reset for one edge, then every address reads 0.
        tick();
        reset_n = 1'b1;
        sweep("reset_sweep");
        tick();   // edge with wr_en=0 and wr_addr=X
        sweep("x_addr_idle");

        // Write/readback.
        set_wr(1'b1, 5'd5,  64'h0123_4567_89AB_CDEF); tick();
        set_wr(1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF); tick();
        set_wr(1'b1, 5'd0,  64'h1);                   tick();
        set_wr(1'b0, 5'd0,  64'h0);
        rd(5'd5, 5'd30, "wr_readback");
        rd(5'd0, 5'd1,  "wr_x0");
        sweep("wr_sweep");

        // XZR ignores writes and reads 0.
        set_wr(1'b1, 5'd31, 64'hDEAD_BEEF_0000_0001);
        rd(5'd31, 5'd31, "xzr_during");
        tick();
        set_wr(1'b0, 5'd0, 64'h0);
        rd(5'd31, 5'd31, "xzr_after");
        sweep("xzr_sweep");

        // Same-cycle read of the register being written.
        set_wr(1'b1, 5'd7, 64'hAA); tick();
        set_wr(1'b1, 5'd7, 64'hBB);
        rd(5'd7, 5'd7, "same_cycle");
        tick();
        set_wr(1'b0, 5'd7, 64'h0);
        rd(5'd7, 5'd7, "same_cycle_next");

        // Back-to-back writes to one register: last wins.
        set_wr(1'b1, 5'd12, 64'h1); tick();
        set_wr(1'b1, 5'd12, 64'h2); tick();
        set_wr(1'b0, 5'd0, 64'h0);
        rd(5'd12, 5'd7, "b2b_last_wins");

        // Reset mid-burst: the write at the reset edge is lost.
        set_wr(1'b1, 5'd3, 64'h44); tick();
        reset_n = 1'b0;
        set_wr(1'b1, 5'd3, 64'h55);
        rd(5'd3, 5'd12, "rst_pending");   // no forwarding while reset is low
        tick();
        reset_n = 1'b1;
        set_wr(1'b0, 5'd3, 64'h0);
        rd(5'd3, 5'd12, "rst_cleared");
        set_wr(1'b1, 5'd3, 64'h66); tick();
        set_wr(1'b0, 5'd0, 64'h0);
        rd(5'd3, 5'd3, "rst_then_write");

        // Disabled write: no storage change and no forwarding.
        set_wr(1'b1, 5'd9, 64'h11); tick();
        set_wr(1'b0, 5'd9, 64'h77);
        rd(5'd9, 5'd9, "wr_dis_same");
        tick();
        rd(5'd9, 5'd9, "wr_dis_next");

        // Random writes with overlapping reads.
        for (int k = 0; k < 200; k++) begin
            set_wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   {$urandom, $urandom});
            rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
            tick();
        end
        set_wr(1'b0, 5'd0, 64'h0);
        sweep("rand_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
